// File: rtl/pwm_8bit_if.sv
// Control/output bundle for the 8-bit PWM generator: period and compare
// values in, registered PWM out.
interface pwm_8bit_if;
  logic [7:0] width;
  logic [7:0] cmp;
  logic       PWM;

  modport master (output width, output cmp, input PWM);
  modport slave  (input width, input cmp, output PWM);
endinterface

// File: rtl/pwm_8bit.sv
// Free-running 8-bit PWM generator. Period and compare values are shadowed
// and reloaded only at the period boundary, so the output never glitches.
module pwm_8bit (
  input logic       clk,
  input logic       res,
  pwm_8bit_if.slave bus
);

  logic [7:0] cnt_r;
  logic [7:0] width_sh_r;
  logic [7:0] cmp_sh_r;
  logic       pwm_r;

  logic [7:0] cnt_next_s;
  logic [7:0] width_next_s;
  logic [7:0] cmp_next_s;
  logic       pwm_next_s;

  // Next-state: wrap and reload shadows at the boundary, otherwise count up.
  always_comb begin
    cnt_next_s   = cnt_r;
    width_next_s = width_sh_r;
    cmp_next_s   = cmp_sh_r;
    if (cnt_r == width_sh_r) begin
      cnt_next_s   = 8'd0;
      width_next_s = bus.width;
      cmp_next_s   = bus.cmp;
    end else begin
      cnt_next_s   = cnt_r + 8'd1;
      width_next_s = width_sh_r;
      cmp_next_s   = cmp_sh_r;
    end
    // Output uses post-edge counter and compare so it stays aligned with cnt.
    pwm_next_s = (cnt_next_s < cmp_next_s) ? 1'b1 : 1'b0;
  end

  // State registers with synchronous reset that aborts the current period.
  always_ff @(posedge clk) begin
    if (res) begin
      cnt_r      <= 8'd0;
      width_sh_r <= 8'd0;
      cmp_sh_r   <= 8'd0;
      pwm_r      <= 1'b0;
    end else begin
      cnt_r      <= cnt_next_s;
      width_sh_r <= width_next_s;
      cmp_sh_r   <= cmp_next_s;
      pwm_r      <= pwm_next_s;
    end
  end

  assign bus.PWM = pwm_r;

endmodule

// File: tb/tb_pwm_8bit.sv
// Self-checking bench for pwm_8bit: per-cycle behavioural model plus
// per-period high-count checks derived from the duty-cycle rules.
module tb_pwm_8bit;

  logic clk;
  logic res;
  pwm_8bit_if bus ();

  pwm_8bit dut (.clk(clk), .res(res), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: phase within the current period and captured values.
  int m_phase = 0;
  int m_w = 0;
  int m_c = 0;
  bit m_pwm = 1'b0;

  // Expected high clocks per period for a captured (width, cmp) pair.
  function automatic int exp_high(input int w, input int c);
    if (c == 0) return 0;
    else if (c > w) return w + 1;
    else return c;
  endfunction

  // One clock: advance the model at the edge, compare PWM on the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (res) begin
      m_phase = 0; m_w = 0; m_c = 0;
    end else if (m_phase == m_w) begin
      m_phase = 0; m_w = int'(bus.width); m_c = int'(bus.cmp);
    end else begin
      m_phase = m_phase + 1;
    end
    m_pwm = (m_phase < m_c);
    @(negedge clk);
    vectors++;
    if (bus.PWM !== m_pwm) begin
      miscompares++;
      $display("FAIL cycle_model t=%0t: PWM=%b expected %b (phase %0d w %0d c %0d)",
               $time, bus.PWM, m_pwm, m_phase, m_w, m_c);
    end
  endtask

  task automatic count_high(input int len, output int h);
    h = 0;
    for (int i = 0; i < len; i++) begin
      cyc();
      if (bus.PWM === 1'b1) h++;
    end
  endtask

  task automatic reset_pulse(input int n);
    res = 1'b1;
    repeat (n) cyc();
    res = 1'b0;
  endtask

  task automatic test_reset();
    int h;
    bus.width = 8'($urandom_range(0, 255));
    bus.cmp   = 8'($urandom_range(1, 255));
    res = 1'b1;
    count_high(2, h);
    vectors++;
    if (h !== 0 || bus.PWM !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: high count %0d PWM %b, expected 0 and 0", h, bus.PWM);
    end
    vectors++;
    if (dut.cnt_r !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_cnt: cnt %0h expected 0", dut.cnt_r);
    end
    res = 1'b0;
  endtask

  task automatic test_duty(input logic [7:0] w, input logic [7:0] c, input int want, input string name);
    int h;
    bus.width = w;
    bus.cmp   = c;
    reset_pulse(1);
    for (int p = 0; p < 2; p++) begin
      count_high(int'(w) + 1, h);
      vectors++;
      if (h !== want) begin
        miscompares++;
        $display("FAIL %s period %0d: high clocks %0d expected %0d", name, p, h, want);
      end
    end
  endtask

  task automatic test_midchange();
    int h1, h2;
    bus.width = 8'h7F;
    bus.cmp   = 8'h1F;
    reset_pulse(1);
    count_high(60, h1);
    bus.cmp = 8'h3F;
    count_high(68, h2);
    vectors++;
    if (h1 + h2 !== 31) begin
      miscompares++;
      $display("FAIL midchange_old: high clocks %0d expected 31", h1 + h2);
    end
    count_high(64, h1);
    bus.cmp = 8'h7F;
    count_high(64, h2);
    vectors++;
    if (h1 + h2 !== 63) begin
      miscompares++;
      $display("FAIL midchange_3f: high clocks %0d expected 63", h1 + h2);
    end
    count_high(128, h1);
    vectors++;
    if (h1 !== 127) begin
      miscompares++;
      $display("FAIL midchange_7f: high clocks %0d expected 127", h1);
    end
  endtask

  task automatic test_width_zero();
    int h;
    bus.width = 8'h00;
    bus.cmp   = 8'h01;
    reset_pulse(1);
    count_high(10, h);
    vectors++;
    if (h !== 10 || dut.cnt_r !== 8'd0) begin
      miscompares++;
      $display("FAIL width_zero: high clocks %0d cnt %0h expected 10 and 0", h, dut.cnt_r);
    end
  endtask

  task automatic test_reset_mid();
    int h;
    logic [7:0] nw, nc;
    bus.width = 8'h7F;
    bus.cmp   = 8'h7F;
    reset_pulse(1);
    count_high(65, h);
    vectors++;
    if (h !== 65 || dut.cnt_r !== 8'h40) begin
      miscompares++;
      $display("FAIL reset_mid_pre: high %0d cnt %0h expected 65 and 40", h, dut.cnt_r);
    end
    nw = 8'($urandom_range(1, 200));
    nc = 8'($urandom_range(0, 255));
    bus.width = nw;
    bus.cmp   = nc;
    res = 1'b1;
    cyc();
    vectors++;
    if (bus.PWM !== 1'b0 || dut.cnt_r !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_mid_abort: PWM %b cnt %0h expected 0 and 0", bus.PWM, dut.cnt_r);
    end
    res = 1'b0;
    count_high(int'(nw) + 1, h);
    vectors++;
    if (h !== exp_high(int'(nw), int'(nc))) begin
      miscompares++;
      $display("FAIL reset_mid_fresh: high clocks %0d expected %0d", h, exp_high(int'(nw), int'(nc)));
    end
  endtask

  task automatic test_random();
    bus.width = 8'($urandom_range(0, 12));
    bus.cmp   = 8'($urandom_range(0, 14));
    reset_pulse(1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) bus.width = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      if ($urandom_range(0, 6) == 0) bus.cmp = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 14));
      res = ($urandom_range(0, 79) == 0);
      cyc();
    end
    res = 1'b0;
  endtask

  initial begin
    res = 1'b1;
    bus.width = 8'h00;
    bus.cmp   = 8'h00;
    @(negedge clk);
    test_reset();
    test_duty(8'h7F, 8'h1F, 31, "duty_7f_1f");
    test_midchange();
    test_duty(8'hFF, 8'h1F, 31, "duty_ff_1f");
    test_duty(8'hFF, 8'h3F, 63, "duty_ff_3f");
    test_duty(8'hFF, 8'h7F, 127, "duty_ff_7f");
    test_duty(8'hFF, 8'hFF, 255, "duty_ff_ff");
    test_duty(8'h7F, 8'h00, 0, "duty_cmp_zero");
    test_duty(8'h7F, 8'h90, 128, "duty_cmp_over");
    test_width_zero();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_8bit.md
Name: pwm_8bit

Overview:
- 8-bit free-running pulse-width-modulation generator with one output, `PWM`.
- An internal counter runs over a programmable period set by `width`. `PWM` is high while the counter is below the programmable compare value `cmp`.
- Period and compare values are shadowed and take effect only at a period boundary, so the output never glitches mid-period.
- Used as a peripheral in the CPU microprocessor design.

Parameters:
- None. The counter, period and compare datapaths are fixed at 8 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- res  input  1  synchronous, active-high reset.
- width  input  8  period register value; period length = width+1 clocks.
- cmp  input  8  compare value; number of high clocks per period.
- PWM  output  1  registered PWM output.

Behaviour:
- One clock domain (`clk`). Reset `res` is synchronous and active-high.
- State registers:
  - cnt[7:0]: period counter.
  - width_s[7:0]: shadow of `width`.
  - cmp_s[7:0]: shadow of `cmp`.
  - pwm_q: drives `PWM`.
- Reset (res=1 at a rising edge): cnt=0, width_s=0, cmp_s=0, PWM=0. Reset has priority over all other activity, including mid-period; the current period is aborted immediately.
- Normal operation (res=0), at each rising edge:
  - Period boundary (cnt == width_s): cnt<=0, width_s<=width, cmp_s<=cmp.
  - Otherwise: cnt<=cnt+1.
- First cycle after reset: width_s=0 equals cnt=0, so it is a boundary. The first edge after reset release loads `width` and `cmp`. The first full period starts at cnt=0 with the new values.
- `PWM` is registered and aligned with the counter.
  - At each edge, pwm_q <= (cnt_next < cmp_s_next), using the post-edge values.
  - After any non-reset edge, PWM == (cnt < cmp_s).
  - No combinational path from inputs to `PWM`.
- Changes to `width`/`cmp` mid-period are ignored until the next boundary. Only the values present at the boundary edge are captured.
- Arithmetic is unsigned 8-bit. Because the counter always wraps at width_s (at most 255), it never overflows. width=FF gives a 256-clock period.
- Duty-cycle boundary cases:
  - cmp_s=0: PWM constantly 0.
  - cmp_s > width_s: PWM constantly 1.
  - cmp_s == width_s: PWM high width_s clocks, low 1 clock.
  - width_s=0: period of 1 clock; PWM=1 iff cmp_s>=1.
- Simultaneous events: a `width`/`cmp` change coincident with a boundary edge is captured at that edge.

Test Plan:
- Reset: hold res=1 for 2 clocks with arbitrary width/cmp → PWM=0 and cnt=0 after the first reset edge; PWM stays 0 while res=1.
- width=7F, cmp=1F after reset release → repeating 128-clock period; PWM high exactly 31 clocks (cnt 0..1E), low 97 clocks.
- Change cmp to 3F mid-period, then 7F (width=7F) → the current period finishes with the old duty. Subsequent periods are 63 high / 65 low, then 127 high / 1 low.
- width=FF with cmp=1F, 3F, 7F, FF, each after a 1-clock reset pulse → 256-clock periods with 31, 63, 127 and 255 high clocks respectively.
- Edge cases:
  - cmp=00, width=7F → PWM never high.
  - cmp=90, width=7F → PWM never low.
  - width=00, cmp=01 → PWM constantly 1, cnt stays 0.
- Reset mid-period: assert res at cnt=0x40 (width=7F, cmp=7F) → next edge gives PWM=0, cnt=0. After release, a fresh 128-clock period starts with newly captured inputs.
